// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock show-ahead FIFO with thresholds and sticky error flags
module fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int OVERWRITE = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic              ren,
  input  logic              lock,
  input  logic              clr_err,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic rd_ok, wr_ok, inc, dec;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    almost_full = int'(count) >= AF_LEVEL;
    almost_empty = int'(count) <= AE_LEVEL;
    rd_ok = ren && !lock && !empty;
    wr_ok = wen && (!full || rd_ok || OVERWRITE != 0);
    inc = wr_ok && !rd_ok && !full;
    dec = rd_ok && !wr_ok;
    rdata = (!empty && !lock) ? mem[rptr] : '0;
  end
  always_ff @(posedge clk)
    if (rst_n && wr_ok) mem[wptr] <= wdata;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= nxt(wptr);
      if (rd_ok || (wr_ok && full)) rptr <= nxt(rptr);
      count <= inc ? count + 1'b1 : dec ? count - 1'b1 : count;
      overflow <= (wen && full && !rd_ok) || (overflow && !clr_err);
      underflow <= (ren && !lock && empty) || (underflow && !clr_err);
    end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: three FIFO variants on shared stimulus, checked against a queue model
module tb_fifo_param;
  logic clk = 0, rst_n = 0, wen = 0, ren = 0, lock = 0, clr_err = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rd0, rd1, rd2;
  logic [4:0] cn0, cn1;
  logic [2:0] cn2;
  logic f0, e0, af0, ae0, ov0, un0;
  logic f1, e1, af1, ae1, ov1, un1;
  logic f2, e2, af2, ae2, ov2, un2;
  int errs = 0, checks = 0;
  bit live = 0;
  logic [7:0] q [3][$];
  int dep [3] = '{16, 16, 5};
  bit ow [3] = '{0, 1, 0};
  bit ovm [3], unm [3];
  always #5 clk = ~clk;
  fifo_param #(.DEPTH(16), .OVERWRITE(0)) u0 (.clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .lock(lock),
    .clr_err(clr_err), .wdata(wdata), .rdata(rd0), .count(cn0), .full(f0), .empty(e0), .almost_full(af0),
    .almost_empty(ae0), .overflow(ov0), .underflow(un0));
  fifo_param #(.DEPTH(16), .OVERWRITE(1)) u1 (.clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .lock(lock),
    .clr_err(clr_err), .wdata(wdata), .rdata(rd1), .count(cn1), .full(f1), .empty(e1), .almost_full(af1),
    .almost_empty(ae1), .overflow(ov1), .underflow(un1));
  fifo_param #(.DEPTH(5), .OVERWRITE(0)) u2 (.clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .lock(lock),
    .clr_err(clr_err), .wdata(wdata), .rdata(rd2), .count(cn2), .full(f2), .empty(e2), .almost_full(af2),
    .almost_empty(ae2), .overflow(ov2), .underflow(un2));
  task automatic step_model(int i);
    int n;
    bit full_now, rd_ok, wr_ok;
    n = q[i].size();
    if (!rst_n) begin
      q[i].delete();
      ovm[i] = 0;
      unm[i] = 0;
    end else begin
      full_now = n == dep[i];
      rd_ok = ren && !lock && n > 0;
      wr_ok = wen && (!full_now || rd_ok || ow[i]);
      ovm[i] = (wen && full_now && !rd_ok) || (ovm[i] && !clr_err);
      unm[i] = (ren && !lock && n == 0) || (unm[i] && !clr_err);
      if (rd_ok || (wr_ok && full_now)) void'(q[i].pop_front());
      if (wr_ok) q[i].push_back(wdata);
    end
  endtask
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) step_model(i);
    live = 1;
  end
  task automatic cmp(int i, logic [7:0] rd, int cn, logic f, logic e, logic af, logic ae, logic ov, logic un);
    int n;
    logic [7:0] erd;
    logic [5:0] ef;
    n = q[i].size();
    erd = (n > 0 && !lock) ? q[i][0] : 8'h00;
    ef = {n == dep[i], n == 0, n >= dep[i] - 2, n <= 2, ovm[i], unm[i]};
    checks++;
    if (rd !== erd || cn != n || {f, e, af, ae, ov, un} !== ef) begin
      errs++;
      $display("FAIL model u%0d t=%0t: got rdata=%h count=%0d flags=%b, expected rdata=%h count=%0d flags=%b",
               i, $time, rd, cn, {f, e, af, ae, ov, un}, erd, n, ef);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (live) begin
      cmp(0, rd0, int'(cn0), f0, e0, af0, ae0, ov0, un0);
      cmp(1, rd1, int'(cn1), f1, e1, af1, ae1, ov1, un1);
      cmp(2, rd2, int'(cn2), f2, e2, af2, ae2, ov2, un2);
    end
  end
  task automatic lit(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask
  task automatic drive(logic w, logic r, logic [7:0] d);
    wen = w;
    ren = r;
    wdata = d;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    drive(0, 0, 0);
    rst_n = 1;
  endtask
  task automatic fill16();
    for (int k = 0; k < 16; k++) drive(1, 0, 8'(k));
  endtask
  initial begin
    rst_n = 0;
    drive(1, 1, 8'h99);
    drive(1, 1, 8'h99);
    lit("reset count", int'(cn0), 0);
    lit("reset empty", int'(e0), 1);
    lit("reset rdata", int'(rd0), 0);
    lit("reset flags", int'({ov0, un0, f0}), 0);
    rst_n = 1;
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 8'(k));
      if (k == 12) lit("almost_full at 13", int'(af0), 0);
      if (k == 13) lit("almost_full at 14", int'(af0), 1);
      if (k == 14) lit("full at 15", int'(f0), 0);
    end
    lit("full at 16", int'(f0), 1);
    for (int k = 0; k < 16; k++) begin
      lit("drain order", int'(rd0), k);
      drive(0, 1, 0);
    end
    lit("drained empty", int'(e0), 1);
    lit("drained underflow", int'(un0), 0);
    do_reset();
    for (int k = 0; k < 3; k++) drive(1, 0, 8'(8'h10 + k));
    for (int k = 0; k < 12; k++) begin
      lit("wrap order", int'(rd2), k < 3 ? 8'h10 + k : 8'h20 + k - 3);
      drive(1, 1, 8'(8'h20 + k));
      lit("wrap count", int'(cn2), 3);
    end
    for (int k = 9; k < 12; k++) begin
      lit("wrap tail", int'(rd2), 8'h20 + k);
      drive(0, 1, 0);
    end
    do_reset();
    fill16();
    drive(1, 0, 8'hAA);
    lit("drop rdata", int'(rd0), 8'h00);
    lit("drop overflow", int'(ov0), 1);
    lit("ovw rdata", int'(rd1), 8'h01);
    lit("ovw overflow", int'(ov1), 1);
    lit("ovw count", int'(cn1), 16);
    for (int k = 0; k < 15; k++) drive(0, 1, 0);
    lit("ovw last pop", int'(rd1), 8'hAA);
    drive(0, 1, 0);
    do_reset();
    fill16();
    drive(1, 1, 8'h77);
    lit("full wr+rd count", int'(cn0), 16);
    lit("full wr+rd overflow", int'(ov0), 0);
    for (int k = 0; k < 16; k++) drive(0, 1, 0);
    drive(1, 1, 8'h55);
    lit("empty wr+rd count", int'(cn0), 1);
    lit("empty wr+rd rdata", int'(rd0), 8'h55);
    lit("empty wr+rd underflow", int'(un0), 1);
    clr_err = 1;
    drive(0, 0, 0);
    clr_err = 0;
    lit("clr_err underflow", int'(un0), 0);
    do_reset();
    for (int k = 0; k < 3; k++) drive(1, 0, 8'(8'h30 + k));
    lock = 1;
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0);
      lit("lock rdata", int'(rd0), 0);
      lit("lock count", int'(cn0), 3);
    end
    lit("lock no underflow", int'(un0), 0);
    lock = 0;
    drive(1, 1, 8'h40);
    rst_n = 0;
    drive(1, 1, 8'h41);
    lit("mid-burst reset count", int'(cn0), 0);
    rst_n = 1;
    drive(0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
